// File: rtl/regs_dump_if.sv
// Byte stream from regs_dump to its sink, normally the debug UART transmitter.
interface regs_dump_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/regs_dump.sv
// regs_dump: walks the register file debug port and streams every value out as bytes (REGS_DUMP_ASCII_EN: hex text).
// Latency: first byte two cycles after start, then one address bubble per register.
// Backpressure: pending byte, index and Debug_addr hold while out_ready is low; start while busy is dropped.
module regs_dump #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [6:0]  Debug_addr,
  input  logic [31:0] Debug_regs,
  regs_dump_if.master bus,
  output logic        busy,
  output logic        done
);

`ifdef REGS_DUMP_ASCII_EN
  localparam logic [3:0] LAST_BYTE = 4'd8;
`else
  localparam logic [3:0] LAST_BYTE = 4'd3;
`endif
  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, SEND, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx, idx_nxt;
  logic [31:0] shadow, shadow_nxt;
  logic [3:0]  bcnt, bcnt_nxt;
  logic [7:0]  cur_byte;
  logic        xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 5'd0;
      shadow <= 32'd0;
      bcnt   <= 4'd0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      shadow <= shadow_nxt;
      bcnt   <= bcnt_nxt;
    end
  end

  assign xfer = (state == SEND) && bus.out_ready;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    shadow_nxt = shadow;
    bcnt_nxt   = bcnt;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = 5'd0;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        shadow_nxt = Debug_regs;
        bcnt_nxt   = 4'd0;
        state_nxt  = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (bcnt != LAST_BYTE) begin
            bcnt_nxt = bcnt + 4'd1;
          end else if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 5'd1;
            state_nxt = ADDR;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef REGS_DUMP_ASCII_EN
  logic [4:0] nib_lsb;
  logic [3:0] nib;

  // Most significant nibble goes out first; the ninth byte is the line feed.
  always_comb begin
    nib_lsb = 5'd28 - {bcnt[2:0], 2'b00};
    nib     = shadow[nib_lsb +: 4];
    if (bcnt == LAST_BYTE)
      cur_byte = 8'h0A;
    else if (nib < 4'd10)
      cur_byte = 8'h30 + {4'h0, nib};
    else
      cur_byte = 8'h57 + {4'h0, nib};
  end
`else
  logic [4:0] byte_lsb;

  always_comb begin
    byte_lsb = 5'd24 - {bcnt[1:0], 3'b000};
    cur_byte = shadow[byte_lsb +: 8];
  end
`endif

  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = (state == SEND) ? cur_byte : 8'h00;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign Debug_addr    = {2'b00, busy ? idx : 5'd0};

endmodule

// File: tb/tb_regs_dump.sv
// Scoreboard bench for regs_dump: expected byte stream is built from a model register array at each start.
module tb_regs_dump;

`ifdef REGS_DUMP_ASCII_EN
  localparam int NREGS = 32;
  localparam int BPR   = 9;
`else
  localparam int NREGS = 4;
  localparam int BPR   = 4;
`endif

  typedef struct packed {
    logic [7:0] b;
    logic [4:0] r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  debug_addr;
  logic [31:0] debug_regs;
  logic        busy;
  logic        done;
  logic [31:0] regs [0:31];

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  int   exp_dones = 0;
  int   e_start = -1;
  bit   chk_timing = 1'b0;
  int   rdy_mode = 0;

  regs_dump_if bus ();

  regs_dump #(.NUM_REGS(NREGS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .Debug_addr (debug_addr),
    .Debug_regs (debug_regs),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign debug_regs = (debug_addr == 7'd0) ? 32'h0 : regs[debug_addr[4:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: each register becomes eight lowercase hex digits plus LF, or four raw bytes MSB first.
  task automatic push_dump();
    string hexd = "0123456789abcdef";
    exp_t  e;
    for (int r = 0; r < NREGS; r++) begin
      logic [31:0] v;
      v   = (r == 0) ? 32'h0 : regs[r];
      e.r = r[4:0];
`ifdef REGS_DUMP_ASCII_EN
      for (int k = 7; k >= 0; k--) begin
        e.b = hexd[v[4*k +: 4]];
        exp_q.push_back(e);
      end
      e.b = 8'h0A;
      exp_q.push_back(e);
`else
      for (int k = 3; k >= 0; k--) begin
        e.b = v[8*k +: 8];
        exp_q.push_back(e);
      end
`endif
    end
  endtask

  task automatic do_start(input bit timing);
    check("idle_before_start", busy, 0);
    chk_timing = timing;
    push_dump();
    exp_dones++;
    acc_cnt = 0;
    e_start = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, required one within %0d cycles", budget);
    end
    tick();
    chk_timing = 1'b0;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (acc_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got %0d bytes, required %0d", acc_cnt, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_data"}, bus.out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, debug_addr, 0);
  endtask

  initial begin : ready_drv
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_done;
    exp_t       e;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, prev_data);
        end
        if (chk_timing && cyc == e_start) begin
          check("addr_no_valid", bus.out_valid, 0);
          check("busy_in_addr", busy, 1);
        end
        if (chk_timing && cyc == e_start + 1)
          check("first_valid", bus.out_valid, 1);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %h at addr %0d, required no transfer", bus.out_data, debug_addr);
          end else begin
            e = exp_q.pop_front();
            check("byte_addr", {17'h0, debug_addr, bus.out_data}, {17'h0, 2'b00, e.r, e.b});
            acc_cnt++;
          end
        end
        if (done) begin
          done_cnt++;
          check("done_single", prev_done, 0);
          check("done_q_empty", exp_q.size(), 0);
          check("done_busy", busy, 1);
          if (chk_timing)
            check("done_cycle", cyc, e_start + NREGS * (1 + BPR));
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_done  = done;
      end
    end
  end

  initial begin : main
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1]         = 32'h12345678;
    regs[2]         = 32'hA1B2C3D4;
    regs[NREGS - 1] = 32'hDEADBEEF;

    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst_init");
    rst = 1'b0;
    tick();

    // Full dump, sink always ready: exact timing.
    do_start(1'b1);
    wait_done(NREGS * (1 + BPR) + 20);

    // Random backpressure with a long stall in the middle.
    rdy_mode = 1;
    do_start(1'b0);
    wait_acc(2 * BPR, 2000);
    rdy_mode = 2;
    repeat (50) tick();
    rdy_mode = 1;
    wait_done(5000);
    rdy_mode = 0;
    tick();

    // Register file write while x1 is being sent.
    do_start(1'b0);
    wait_acc(BPR + 3, 500);
    regs[1] = 32'hFFFFFFFF;
    wait_done(NREGS * (1 + BPR) + 20);
    regs[1] = 32'h12345678;

    // start pulses while busy are dropped.
    do_start(1'b0);
    repeat (3) begin
      repeat ($urandom_range(1, 4)) tick();
      check("busy_on_restart", busy, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_done(NREGS * (1 + BPR) + 20);
    repeat (NREGS * (1 + BPR) + 5) tick();
    check("idle_after_ignored", busy, 0);

    // Reset in the middle of x1, then a fresh dump from x0.
    do_start(1'b0);
    wait_acc(BPR + 2, 500);
    check("valid_before_rst", bus.out_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    exp_dones--;
    tick();
    check_reset_outputs("rst_mid1");
    tick();
    check_reset_outputs("rst_mid2");
    rst = 1'b0;
    tick();
    do_start(1'b1);
    wait_done(NREGS * (1 + BPR) + 20);

    repeat (5) tick();
    check("final_q_empty", exp_q.size(), 0);
    check("done_count", done_cnt, exp_dones);
    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #900000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
